iserdes_align_ctrl: RTL and testbench

ISERDES_ALIGN_CTRL -- requirements
Module: iserdes_align_ctrl

---
 rtl/serdes_pkg.sv | 19 +
 rtl/iserdes_align_ctrl.sv | 116 +++++++++++
 tb/tb_iserdes_align_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES word-alignment logic: FSM state encoding,
// counter width and a saturating counter increment.
package serdes_pkg;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_SLIP   = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/iserdes_align_ctrl.sv
// Word aligner for an ISERDESE2: watches the parallel word for the training pattern
// and pulses BITSLIP until it is seen MATCH_N times in a row, then monitors for lock loss.
module iserdes_align_ctrl
  import serdes_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'h0E,
  parameter int         SETTLE        = 3,
  parameter int         MATCH_N       = 4,
  parameter int         MAX_SLIP      = 8,
  parameter int         LOSS_N        = 4
) (
  input  logic       clkdiv,
  input  logic       rst,
  input  logic [7:0] q,
  input  logic       start,
  output logic       bitslip,
  output logic       locked,
  output logic       align_err,
  output logic       busy,
  output logic [3:0] slip_cnt
);

  localparam cnt_t SETTLE_C   = cnt_t'(SETTLE);
  localparam cnt_t MATCH_LAST = cnt_t'(MATCH_N - 1);
  localparam cnt_t LOSS_LAST  = cnt_t'(LOSS_N - 1);
  localparam cnt_t MAX_SLIP_C = cnt_t'(MAX_SLIP);

  logic [2:0] state, state_n;
  cnt_t       settle_cnt, settle_n;
  cnt_t       match_cnt, match_n;
  cnt_t       miss_cnt, miss_n;
  cnt_t       slip_n;

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    match_n  = match_cnt;
    miss_n   = miss_cnt;
    slip_n   = slip_cnt;
    case (state)
      ST_IDLE, ST_FAIL: begin
        if (start) begin
          state_n  = ST_SETTLE;
          settle_n = SETTLE_C;
          match_n  = '0;
          miss_n   = '0;
          slip_n   = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt <= cnt_t'(1)) state_n = ST_CHECK;
        else                         settle_n = settle_cnt - cnt_t'(1);
      end
      ST_CHECK: begin
        // An all-zero word means the link carries no data yet, so it says nothing about alignment.
        if (q == 8'h00) begin
          state_n = ST_CHECK;
        end else if (q == TRAIN_PATTERN) begin
          match_n = sat_inc(match_cnt);
          if (match_cnt >= MATCH_LAST) begin
            state_n = ST_LOCKED;
            miss_n  = '0;
          end
        end else begin
          match_n = '0;
          state_n = (slip_cnt >= MAX_SLIP_C) ? ST_FAIL : ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_n   = sat_inc(slip_cnt);
        settle_n = SETTLE_C;
        state_n  = ST_SETTLE;
      end
      ST_LOCKED: begin
        if (start || (q != TRAIN_PATTERN && miss_cnt >= LOSS_LAST)) begin
          state_n  = ST_SETTLE;
          settle_n = SETTLE_C;
          match_n  = '0;
          miss_n   = '0;
          slip_n   = '0;
        end else if (q == TRAIN_PATTERN) begin
          miss_n = '0;
        end else begin
          miss_n = sat_inc(miss_cnt);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Status flags decode the next state so they rise in the same cycle the state is entered.
  always_ff @(posedge clkdiv) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      match_cnt  <= match_n;
      miss_cnt   <= miss_n;
      slip_cnt   <= slip_n;
      bitslip    <= (state_n == ST_SLIP);
      locked     <= (state_n == ST_LOCKED);
      align_err  <= (state_n == ST_FAIL);
      busy       <= (state_n == ST_SETTLE) || (state_n == ST_CHECK) || (state_n == ST_SLIP);
    end
  end

endmodule

// File: tb/tb_iserdes_align_ctrl.sv
// Directed bench for iserdes_align_ctrl with a simple deserializer model that
// rotates q on each bitslip pulse.
module tb_iserdes_align_ctrl;

  logic       clkdiv = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] q      = 8'h00;
  logic       start  = 1'b0;
  logic       bitslip, locked, align_err, busy;
  logic [3:0] slip_cnt;

  int total = 0;
  int bad   = 0;

  iserdes_align_ctrl dut (
    .clkdiv    (clkdiv),
    .rst       (rst),
    .q         (q),
    .start     (start),
    .bitslip   (bitslip),
    .locked    (locked),
    .align_err (align_err),
    .busy      (busy),
    .slip_cnt  (slip_cnt)
  );

  always #5 clkdiv = ~clkdiv;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    @(negedge clkdiv) rst = 1'b1;
    start = 1'b0;
    @(negedge clkdiv);
    @(negedge clkdiv) rst = 1'b0;
  endtask

  // Returns at the negedge just after the edge that sampled start.
  task automatic pulse_start();
    @(negedge clkdiv) start = 1'b1;
    @(negedge clkdiv) start = 1'b0;
  endtask

  task automatic wait_lock(output int n, output int slips);
    n = 0;
    slips = 0;
    while (!locked && n < 100) begin
      @(negedge clkdiv);
      n++;
      if (bitslip) slips++;
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    total++; if ({bitslip, locked, align_err, busy} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bitslip, locked, align_err, busy}); end
    total++; if (slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_slip_cnt: got %0d expected 0", slip_cnt); end
    q = 8'h0E;
    n = 0;
    repeat (5) begin @(negedge clkdiv); if (busy || locked) n++; end
    total++; if (n !== 0) begin bad++; $display("[TB] FAIL idle_without_start: got %0d active cycles expected 0", n); end
  endtask

  task automatic test_aligned();
    int n, slips;
    q = 8'h0E;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL aligned_busy: got %b expected 1", busy); end
    wait_lock(n, slips);
    total++; if (n !== 7) begin bad++; $display("[TB] FAIL aligned_latency: got %0d expected 7", n); end
    total++; if (slips !== 0) begin bad++; $display("[TB] FAIL aligned_bitslips: got %0d expected 0", slips); end
    total++; if (slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL aligned_slip_cnt: got %0d expected 0", slip_cnt); end
    total++; if ({busy, align_err} !== 2'b00) begin bad++; $display("[TB] FAIL aligned_flags: got %b expected 00", {busy, align_err}); end
  endtask

  task automatic test_lock_retained();
    int drops = 0;
    q = 8'h55;
    repeat (3) begin @(negedge clkdiv); if (!locked) drops++; end
    q = 8'h0E;
    @(negedge clkdiv); if (!locked) drops++;
    q = 8'h00;
    repeat (3) begin @(negedge clkdiv); if (!locked) drops++; end
    q = 8'h0E;
    repeat (2) begin @(negedge clkdiv); if (!locked) drops++; end
    total++; if (drops !== 0) begin bad++; $display("[TB] FAIL lock_retained: got %0d unlocked cycles expected 0", drops); end
  endtask

  task automatic test_lock_loss();
    int n, slips;
    q = 8'h55;
    repeat (3) @(negedge clkdiv);
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL loss_after3: got %b expected 1", locked); end
    @(negedge clkdiv);
    total++; if ({locked, busy} !== 2'b01) begin bad++; $display("[TB] FAIL loss_after4: got %b expected 01", {locked, busy}); end
    total++; if (slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL loss_slip_cnt: got %0d expected 0", slip_cnt); end
    q = 8'h0E;
    wait_lock(n, slips);
    total++; if (n !== 7) begin bad++; $display("[TB] FAIL realign_latency: got %0d expected 7", n); end
  endtask

  task automatic test_rotation();
    int pulses = 0, last = -100, min_gap = 99, cyc = 0;
    do_reset();
    q = 8'h70;
    pulse_start();
    while (!locked && cyc < 200) begin
      @(negedge clkdiv);
      cyc++;
      if (bitslip) begin
        pulses++;
        if (pulses > 1 && (cyc - last - 1) < min_gap) min_gap = cyc - last - 1;
        last = cyc;
        q = {q[0], q[7:1]};
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL rot_locked: got %b expected 1", locked); end
    total++; if (pulses !== 3) begin bad++; $display("[TB] FAIL rot_pulses: got %0d expected 3", pulses); end
    total++; if (min_gap < 4) begin bad++; $display("[TB] FAIL rot_gap: got %0d expected >=4", min_gap); end
    total++; if (slip_cnt !== 4'd3) begin bad++; $display("[TB] FAIL rot_slip_cnt: got %0d expected 3", slip_cnt); end
  endtask

  task automatic test_never_aligns();
    int pulses = 0, cyc = 0, n, slips;
    q = 8'hAA;
    pulse_start();
    while (!align_err && cyc < 300) begin
      @(negedge clkdiv);
      cyc++;
      if (bitslip) pulses++;
    end
    total++; if (pulses !== 8) begin bad++; $display("[TB] FAIL fail_pulses: got %0d expected 8", pulses); end
    total++; if ({align_err, busy, locked} !== 3'b100) begin bad++; $display("[TB] FAIL fail_flags: got %b expected 100", {align_err, busy, locked}); end
    total++; if (slip_cnt !== 4'd8) begin bad++; $display("[TB] FAIL fail_slip_cnt: got %0d expected 8", slip_cnt); end
    repeat (5) @(negedge clkdiv);
    total++; if (align_err !== 1'b1) begin bad++; $display("[TB] FAIL fail_hold: got %b expected 1", align_err); end
    q = 8'h0E;
    pulse_start();
    total++; if ({align_err, busy} !== 2'b01) begin bad++; $display("[TB] FAIL fail_restart: got %b expected 01", {align_err, busy}); end
    wait_lock(n, slips);
    total++; if (n !== 7 || slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL fail_relock: got %0d cycles slip_cnt %0d expected 7 and 0", n, slip_cnt); end
  endtask

  task automatic test_zero_data();
    int slips = 0, idle = 0, n, s2;
    do_reset();
    q = 8'h00;
    pulse_start();
    repeat (3) @(negedge clkdiv);
    for (int i = 0; i < 20; i++) begin
      @(negedge clkdiv);
      if (bitslip) slips++;
      if (!busy || locked) idle++;
      start = (i == 18);
    end
    start = 1'b0;
    total++; if (slips !== 0) begin bad++; $display("[TB] FAIL zero_bitslips: got %0d expected 0", slips); end
    total++; if (idle !== 0 || slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL zero_hold: got %0d off-check cycles slip_cnt %0d expected 0 and 0", idle, slip_cnt); end
    q = 8'h0E;
    wait_lock(n, s2);
    total++; if (n !== 4) begin bad++; $display("[TB] FAIL zero_then_pattern: got %0d expected 4", n); end
  endtask

  task automatic test_reset_mid_slip();
    int pulses = 0, cyc = 0, n, slips;
    do_reset();
    q = 8'hAA;
    pulse_start();
    while (pulses < 3 && cyc < 100) begin
      @(negedge clkdiv);
      cyc++;
      if (bitslip) pulses++;
    end
    total++; if (pulses !== 3 || slip_cnt !== 4'd2) begin bad++; $display("[TB] FAIL midslip_reach: got %0d pulses slip_cnt %0d expected 3 and 2", pulses, slip_cnt); end
    rst = 1'b1;
    @(negedge clkdiv);
    total++; if ({bitslip, locked, align_err, busy} !== 4'b0000) begin bad++; $display("[TB] FAIL midslip_flags: got %b expected 0000", {bitslip, locked, align_err, busy}); end
    total++; if (slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL midslip_slip_cnt: got %0d expected 0", slip_cnt); end
    rst = 1'b0;
    q = 8'h0E;
    @(negedge clkdiv);
    pulse_start();
    wait_lock(n, slips);
    total++; if (n !== 7 || slips !== 0 || slip_cnt !== 4'd0) begin bad++; $display("[TB] FAIL post_reset_lock: got %0d cycles %0d slips slip_cnt %0d expected 7 0 0", n, slips, slip_cnt); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_lock_retained();
    test_lock_loss();
    test_rotation();
    test_never_aligns();
    test_zero_data();
    test_reset_mid_slip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
